// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared constants for the Wishbone-to-BRAM controller.
// State encoding, default window/wait settings and the wait counter width.
package wb_bram_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [7:0]  DEF_BASE_HI = 8'h38;
  localparam int unsigned DEF_DELAYS  = 10;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

endpackage

// File: rtl/wb_bram_ctrl_if.sv
// wb_bram_ctrl_if: Wishbone classic slave-side bus bundle.
// master modport drives the cycle, slave modport answers it.
interface wb_bram_ctrl_if;
  import wb_bram_pkg::*;

  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic          wbs_we_i;
  logic [SW-1:0] wbs_sel_i;
  logic [DW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic          wbs_ack_o;
  logic [DW-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone classic slave in front of a 1-cycle-latency BRAM.
// Decodes the BASE_HI window, issues one BRAM access per transfer, captures
// read data and returns a one-cycle ack.
// Optional macro WB_BRAM_WAIT_EN inserts DELAYS wait cycles before the ack.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [7:0]  BASE_HI = DEF_BASE_HI,
  parameter int unsigned DELAYS  = DEF_DELAYS
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_bram_ctrl_if.slave wbs,
  output logic          bram_en,
  output logic [SW-1:0] bram_we,
  output logic [DW-1:0] bram_a,
  output logic [DW-1:0] bram_di,
  input  logic [DW-1:0] bram_do
);

  logic [1:0]    state;
  logic          we_q;
  logic          ack_q;
  logic [DW-1:0] dat_q;
  logic          req;
  logic          issue;
  logic          unused_ok;

`ifdef WB_BRAM_WAIT_EN
  logic [CNT_W-1:0] cnt;
`endif

  assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:24] == BASE_HI);

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

`ifdef WB_BRAM_WAIT_EN
  assign unused_ok = ^wbs.wbs_adr_i[1:0];
`else
  assign unused_ok = ^{wbs.wbs_adr_i[1:0], (DELAYS == 0)};
`endif

  // BRAM port is only driven in the IDLE issue cycle; reset also blocks it
  // so a held strobe cannot sneak an access through while reset is high.
  always_comb begin
    issue   = (state == S_IDLE) & req & ~wb_rst_i;
    bram_en = issue;
    bram_we = (issue & wbs.wbs_we_i) ? wbs.wbs_sel_i : '0;
    bram_a  = issue ? {2'b00, wbs.wbs_adr_i[31:2]} : '0;
    bram_di = issue ? wbs.wbs_dat_i : '0;
  end

  // Transfer sequencing: issue, capture, optional wait, single-cycle ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      we_q  <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
`ifdef WB_BRAM_WAIT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (req) begin
            we_q  <= wbs.wbs_we_i;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // Read data lands even if the master aborts this cycle.
          if (!we_q) dat_q <= bram_do;
          if (!wbs.wbs_cyc_i) begin
            state <= S_IDLE;
          end else begin
`ifdef WB_BRAM_WAIT_EN
            cnt   <= CNT_W'(DELAYS - 1);
            state <= S_WAIT;
`else
            ack_q <= 1'b1;
            state <= S_ACK;
`endif
          end
        end
`ifdef WB_BRAM_WAIT_EN
        S_WAIT: begin
          if (!wbs.wbs_cyc_i) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            ack_q <= 1'b1;
            state <= S_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_ACK: begin
          ack_q <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: directed bench for wb_bram_ctrl with a behavioural BRAM.
// Ack latency expectations follow WB_BRAM_WAIT_EN when it is defined.
module tb_wb_bram_ctrl;
  import wb_bram_pkg::*;

  localparam int unsigned TB_DELAYS = 10;
`ifdef WB_BRAM_WAIT_EN
  localparam int unsigned ACK_LAT = 2 + TB_DELAYS;
  localparam int unsigned ABORT_T = 5;
`else
  localparam int unsigned ACK_LAT = 2;
  localparam int unsigned ABORT_T = 1;
`endif

  logic        clk;
  logic        rst;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_a;
  logic [31:0] bram_di;
  logic [31:0] bram_do;
  logic [31:0] mem [0:255];

  int unsigned n_total;
  int unsigned n_pass;

  wb_bram_ctrl_if wbs ();

  wb_bram_ctrl #(
    .BASE_HI (8'h38),
    .DELAYS  (TB_DELAYS)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (wbs),
    .bram_en  (bram_en),
    .bram_we  (bram_we),
    .bram_a   (bram_a),
    .bram_di  (bram_di),
    .bram_do  (bram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM with byte writes; output is 0 after a disabled cycle.
  always @(posedge clk) begin
    if (bram_en) begin
      bram_do <= mem[bram_a[7:0]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_a[7:0]][8*b +: 8] <= bram_di[8*b +: 8];
    end else begin
      bram_do <= '0;
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  exp_we;
    logic [31:0] exp_a;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_bus();
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = '0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;
  endtask

  // One full transfer; t0 is the cycle the request is driven in.
  task automatic txn(input vec_t v, input string tag);
    logic early, unstable;
    early = 1'b0;
    unstable = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = v.we;
    wbs.wbs_sel_i = v.sel;
    wbs.wbs_adr_i = v.adr;
    wbs.wbs_dat_i = v.dat;
    #1;
    chk({tag, ".en"}, 32'(bram_en), 32'd1);
    chk({tag, ".we"}, 32'(bram_we), 32'(v.exp_we));
    chk({tag, ".a"},  bram_a, v.exp_a);
    chk({tag, ".di"}, bram_di, v.dat);
    for (int c = 1; c < int'(ACK_LAT); c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o !== 1'b0) early = 1'b1;
      if (c >= 2 && !v.we && wbs.wbs_dat_o !== v.exp_rd) unstable = 1'b1;
    end
    chk({tag, ".early_ack"}, 32'(early), 32'd0);
    chk({tag, ".dat_stable"}, 32'(unstable), 32'd0);
    @(negedge clk);
    chk({tag, ".ack"}, 32'(wbs.wbs_ack_o), 32'd1);
    chk({tag, ".en_in_ack"}, 32'(bram_en), 32'd0);
    if (!v.we) last_rd = v.exp_rd;
    chk({tag, ".dat_o"}, wbs.wbs_dat_o, last_rd);
    idle_bus();
    @(negedge clk);
    chk({tag, ".ack_drop"}, 32'(wbs.wbs_ack_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_en, saw_ack;
    n_total = 0;
    n_pass  = 0;
    last_rd = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    //          we    sel    adr           dat           exp_we  exp_a         exp_rd
    vecs[0] = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 32'h0E00_0004, 32'h0};
    vecs[1] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         4'h0, 32'h0E00_0004, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'h2, 32'h3800_0010, 32'h0000_AB00, 4'h2, 32'h0E00_0004, 32'h0};
    vecs[3] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         4'h0, 32'h0E00_0004, 32'hDEAD_ABEF};
    vecs[4] = '{1'b1, 4'h9, 32'h3800_0020, 32'h1122_3344, 4'h9, 32'h0E00_0008, 32'h0};
    vecs[5] = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,         4'h0, 32'h0E00_0008, 32'h1100_0044};
    vecs[6] = '{1'b0, 4'hF, 32'h3800_0024, 32'h0,         4'h0, 32'h0E00_0009, 32'h0};
    vecs[7] = '{1'b1, 4'hC, 32'h3800_0024, 32'hA5A5_5A5A, 4'hC, 32'h0E00_0009, 32'h0};
    vecs[8] = '{1'b0, 4'h0, 32'h3800_0024, 32'hFFFF_FFFF, 4'h0, 32'h0E00_0009, 32'hA5A5_0000};

    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("rst.dat_o", wbs.wbs_dat_o, 32'd0);
    chk("rst.en", 32'(bram_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Out-of-window request held for 20 cycles.
    saw_en = 1'b0;
    saw_ack = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_adr_i = 32'h3000_0000;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bram_en !== 1'b0) saw_en = 1'b1;
      if (wbs.wbs_ack_o !== 1'b0) saw_ack = 1'b1;
      @(negedge clk);
    end
    chk("oow.en", 32'(saw_en), 32'd0);
    chk("oow.ack", 32'(saw_ack), 32'd0);
    idle_bus();

    // Abort a read of word 4 after capture; data still lands, no ack.
    saw_ack = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_adr_i = 32'h3800_0010;
    for (int c = 1; c <= int'(ABORT_T); c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o !== 1'b0) saw_ack = 1'b1;
    end
    idle_bus();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o !== 1'b0) saw_ack = 1'b1;
    end
    chk("abort.ack", 32'(saw_ack), 32'd0);
    chk("abort.dat_o", wbs.wbs_dat_o, 32'hDEAD_ABEF);
    last_rd = 32'hDEAD_ABEF;
    txn(vecs[5], "post_abort");

    // Reset while the read sits in CAPTURE.
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_adr_i = 32'h3800_0024;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid.ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("rstmid.dat_o", wbs.wbs_dat_o, 32'd0);
    chk("rstmid.en", 32'(bram_en), 32'd0);
    @(negedge clk);
    chk("rstmid.en_held", 32'(bram_en), 32'd0);
    idle_bus();
    @(negedge clk);
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o !== 1'b0) saw_ack = 1'b1;
    end
    chk("rstmid.no_ack", 32'(saw_ack), 32'd0);
    last_rd = '0;
    txn(vecs[3], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_bram_ctrl.md
# wb_bram_ctrl

Wishbone classic slave that sits directly upstream of the user-project BRAM and turns CPU bus cycles into BRAM port accesses. Decodes the user memory window, drives the BRAM's enable, byte-write, address and data lines, and captures the BRAM's one-cycle-latency read data. Generates a one-cycle `wbs_ack_o` per transfer, with optional programmable wait states that emulate slow memory.

## Interface
- `BASE_HI`, 8'h38: required value of `wbs_adr_i[31:24]` for a cycle to be accepted.
- `DELAYS`, 10: extra wait cycles before ack when the wait feature is compiled in; legal range 1..255.
- `wb_clk_i` in 1: single clock for the block and the BRAM.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_cyc_i` in 1: bus cycle.
- `wbs_stb_i` in 1: strobe.
- `wbs_we_i` in 1: write (1) or read (0).
- `wbs_sel_i` in 4: byte lane enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: transfer acknowledge, registered.
- `wbs_dat_o` out 32: read data, registered.
- `bram_en` out 1: to BRAM `EN0`.
- `bram_we` out 4: to BRAM `WE0`.
- `bram_a` out 32: word address to BRAM `A0`.
- `bram_di` out 32: to BRAM `Di0`.
- `bram_do` in 32: from BRAM `Do0`. Valid the cycle after an enabled access; reads 0 when `EN0` was low.

## Operation
- Request: `req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI)`. Out-of-window cycles are ignored: no BRAM access and no ack.
- FSM states: IDLE, CAPTURE, WAIT (present only with the macro), ACK.
- IDLE:
  - `bram_en = req`.
  - `bram_we = (req & wbs_we_i) ? wbs_sel_i : 0`.
  - `bram_a = {2'b0, wbs_adr_i[31:2]}` when `req`, else 0.
  - `bram_di = wbs_dat_i` when `req`, else 0.
  - On `req`, go to CAPTURE.
- CAPTURE:
  - `bram_en` and `bram_we` are 0.
  - On a read, `wbs_dat_o <= bram_do` at the end of this cycle. On a write, `wbs_dat_o` is unchanged.
  - Next state is WAIT if compiled in, otherwise ACK. `wbs_ack_o` is registered so that it is high while in ACK.
- WAIT: counter loads `DELAYS - 1` on entry and decrements each cycle. At 0, go to ACK.
- ACK: `wbs_ack_o = 1` for exactly one cycle, then unconditionally IDLE. A `stb` still high during ACK is not re-accepted.
- Abort: if `wbs_cyc_i` drops in CAPTURE or WAIT, return to IDLE with no ack. A write has already been committed to the BRAM; a read capture still updates `wbs_dat_o`.
- Partial writes: each byte lane is written only if its `wbs_sel_i` bit is set. Reads ignore `sel` and return the full word.
- `wbs_dat_o` holds the last read value until the next read.

## Timing
- Reset: state IDLE, `wbs_ack_o = 0`, `wbs_dat_o = 0`, counter 0. `bram_en`, `bram_we`, `bram_a` and `bram_di` are 0 because state is IDLE and `req` is gated.
- Reset asserted mid-transfer: immediate return to IDLE. No ack is produced afterwards and no further BRAM enable is issued.
- Issue cycle is t0, the IDLE cycle with `req`. BRAM samples on the t0→t1 edge.
- Ack latency without the macro: `wbs_ack_o` high in t2, IDLE in t3. Earliest next issue is t3.
- Ack latency with the macro: `wbs_ack_o` high in t(2+`DELAYS`).
- Back-to-back transfers: throughput is one transfer per 3 cycles (no macro), or 3+`DELAYS` (with macro).

## Configuration
- `WB_BRAM_WAIT_EN`
  - Defined: WAIT state and counter are compiled in. Each transfer is extended by `DELAYS` cycles.
  - Undefined: no WAIT state or counter logic. CAPTURE goes straight to ACK, and `DELAYS` is ignored.

## Structure
- Package `wb_bram_pkg` holds:
  - the state encoding (IDLE/CAPTURE/WAIT/ACK);
  - `BASE_HI` default 8'h38;
  - `DELAYS` default 10;
  - counter width 8.
- No sub-module. The counter is small and stays inline. The BRAM itself is instantiated beside this block by the parent user-project module, not inside it.

## Test plan
- Write `adr=0x3800_0010`, `sel=4'hF`, `dat=0xDEADBEEF`:
  - `bram_en=1`, `bram_we=4'hF`, `bram_a=0x0E00_0004` in t0;
  - ack one cycle in t2 (macro off);
  - read back returns `0xDEADBEEF`.
- Partial write `sel=4'b0010`, `dat=0x0000AB00` to the same word → read returns `0xDEADABEF`.
- Out-of-window read `adr=0x3000_0000`, cyc/stb held 20 cycles → `bram_en` never 1, no ack.
- `WB_BRAM_WAIT_EN` defined, `DELAYS=10`, read → ack exactly at t12 for one cycle; `wbs_dat_o` stable from t2.
- Drop `cyc` in WAIT at t5 → no ack ever; state IDLE next cycle; a following request is issued normally.
- Assert `wb_rst_i` in CAPTURE → ack stays 0, `wbs_dat_o = 0`; after release, a fresh read completes with correct data.
